// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// index-width helper and the reset constants used by the arbiter state.
package register_write_arbiter_pkg;

    // Ceiling log2 with a floor of 1 so a 1-bit index is always available.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << r) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam logic RST_DATA_BIT = 1'b0;
    localparam logic RST_GNT_BIT  = 1'b0;
    localparam logic RST_VALID    = 1'b0;
    localparam int   RST_IDX      = 0;

endpackage : register_write_arbiter_pkg

// File: rtl/register_write_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: level requests with
// flattened data in, grant pulse, register contents and owner back out.
interface register_write_arbiter_if
    import register_write_arbiter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         q_out;
    logic [IDX_W-1:0]         owner;
    logic                     valid;

    modport master (
        output req, wr_data,
        input  gnt, q_out, owner, valid
    );

    modport slave (
        input  req, wr_data,
        output gnt, q_out, owner, valid
    );
endinterface : register_write_arbiter_if

// File: rtl/register_load_and_reset.sv
// Loadable register with asynchronous active-low clear; holds its value
// whenever load is low.
module register_load_and_reset #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= {WIDTH{1'b0}};
        end else if (load) begin
            q <= data_in;
        end
    end
endmodule : register_load_and_reset

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter that lets NUM_REQ producers share one loadable register,
// returning a one-cycle grant to the winner and tracking the last writer.
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    register_write_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0] eff_req;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   owner_q;
    logic               found;
    logic               valid_q;
    logic [WIDTH-1:0]   data_sel;
    logic [IDX_W:0]     scan;

    // The last winner is masked for one cycle so it can drop req in its
    // grant cycle without being written twice.
    assign eff_req = bus.req & ~gnt_q;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_REQ)) scan = scan - (IDX_W+1)'(NUM_REQ);
            if (!found && eff_req[scan[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                gnt_oh[i] = found;
                data_sel  = bus.wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant, owner, valid and pointer update on the same edge as the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q   <= {NUM_REQ{RST_GNT_BIT}};
            owner_q <= IDX_W'(RST_IDX);
            valid_q <= RST_VALID;
            ptr     <= IDX_W'(RST_IDX);
        end else if (found) begin
            gnt_q   <= gnt_oh;
            owner_q <= winner;
            valid_q <= 1'b1;
            ptr     <= (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end else begin
            gnt_q   <= {NUM_REQ{RST_GNT_BIT}};
        end
    end

    register_load_and_reset #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (found),
        .data_in (data_sel),
        .q       (bus.q_out)
    );

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.valid = valid_q;
endmodule : register_write_arbiter

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter: reset, single requester,
// contention, wrap-around, mid-operation reset and idle hold.
module tb_register_write_arbiter;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    register_write_arbiter_if #(.WIDTH(4), .NUM_REQ(4)) bus ();

    register_write_arbiter #(
        .WIDTH   (4),
        .NUM_REQ (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] q, input logic [3:0] g,
                             input logic [1:0] own, input logic vld);
        check({tag, ".q_out"}, 16'(bus.q_out), 16'(q));
        check({tag, ".gnt"},   16'(bus.gnt),   16'(g));
        check({tag, ".owner"}, 16'(bus.owner), 16'(own));
        check({tag, ".valid"}, 16'(bus.valid), 16'(vld));
        check({tag, ".onehot"}, 16'($countones(bus.gnt) <= 1), 16'd1);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset_n     = 1'b0;
        bus.req     = 4'b1111;
        bus.wr_data = 16'h4321;

        // 1. Reset with requests pending, then idle after release
        repeat (3) step();
        check_all("rst", 4'h0, 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b0000;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("rst_idle", 4'h0, 4'b0000, 2'd0, 1'b0);
        end

        // 2. Single requester 2, held high: grant, masked, grant again
        bus.wr_data = 16'h0300;
        bus.req     = 4'b0100;
        step();
        check_all("single_w1", 4'h3, 4'b0100, 2'd2, 1'b1);
        step();
        check_all("single_mask", 4'h3, 4'b0000, 2'd2, 1'b1);
        step();
        check_all("single_w2", 4'h3, 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b0000;
        step();
        check_all("single_idle", 4'h3, 4'b0000, 2'd2, 1'b1);

        // 3. Reset to ptr=0, then full contention
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        bus.wr_data = 16'h4321;
        bus.req     = 4'b1111;
        step();
        check_all("full_0", 4'h1, 4'b0001, 2'd0, 1'b1);
        step();
        check_all("full_1", 4'h2, 4'b0010, 2'd1, 1'b1);
        step();
        check_all("full_2", 4'h3, 4'b0100, 2'd2, 1'b1);
        step();
        check_all("full_3", 4'h4, 4'b1000, 2'd3, 1'b1);
        step();
        check_all("full_4", 4'h1, 4'b0001, 2'd0, 1'b1);

        // 4. Requester 2 wins (ptr=3), then req 1001 wraps: 3 before 0
        bus.req = 4'b0100;
        step();
        check_all("wrap_pre", 4'h3, 4'b0100, 2'd2, 1'b1);
        bus.wr_data = 16'hA00B;
        bus.req     = 4'b1001;
        step();
        check_all("wrap_3", 4'hA, 4'b1000, 2'd3, 1'b1);
        step();
        check_all("wrap_0", 4'hB, 4'b0001, 2'd0, 1'b1);

        // 5. Reset between edges under contention, release with req 0011
        bus.wr_data = 16'h4321;
        bus.req     = 4'b1111;
        step();
        check_all("mid_pre", 4'h2, 4'b0010, 2'd1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_all("mid_rst", 4'h0, 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b0011;
        #2 reset_n = 1'b1;
        step();
        check_all("mid_rel", 4'h1, 4'b0001, 2'd0, 1'b1);

        // 6. Requester 1 writes C, then idle for 5 cycles
        bus.wr_data = 16'h00C0;
        bus.req     = 4'b0010;
        step();
        check_all("hold_w", 4'hC, 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all("hold", 4'hC, 4'b0000, 2'd1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule : tb_register_write_arbiter

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares one loadable register among NUM_REQ write requesters using round-robin arbitration.
- Each cycle it picks at most one pending requester and drives the register's load and data_in from that requester.
- It returns a one-cycle grant pulse to the winner and reports which requester performed the last write.
- Sits in front of the register_load_and_reset datapath element wherever several producers update a shared register.

Parameters:
- WIDTH, 4, data width of the shared register and of each requester's data.
- NUM_REQ, 4, number of requesters; must be at least 2, and need not be a power of 2.
- IDX_W, clog2(NUM_REQ), width of the requester index.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request, level.
- wr_data  input  NUM_REQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant, a one-cycle pulse.
- q_out  output  WIDTH  shared register contents.
- owner  output  IDX_W  index of the requester that last wrote q_out.
- valid  output  1  high once at least one write has occurred since reset.

Behaviour:
- Reset, asynchronous on reset_n=0, takes effect immediately without waiting for a clock edge:
  - q_out=0, gnt=0, owner=0, valid=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
- Effective request: eff_req = req & ~gnt.
  - A requester granted at the last edge is masked for exactly one cycle.
  - This lets it drop req in the gnt cycle without a double write.
  - A requester that keeps req high continuously wins at most every other cycle.
- Winner: the first set bit of eff_req, scanning from index ptr upward and wrapping from NUM_REQ-1 to 0. Selection is combinational.
- Rising edge with eff_req != 0:
  - register load=1, data_in = wr_data of the winner, so q_out takes the winner's data.
  - gnt = onehot(winner), owner = winner, valid = 1.
  - ptr = winner+1, wrapping from NUM_REQ-1 to 0.
- Rising edge with eff_req == 0:
  - load=0; q_out, owner, valid and ptr hold.
  - gnt = 0.
- Latency: a request sampled at edge k updates q_out and gnt immediately after edge k, i.e. a 1-edge write latency. gnt is the write acknowledge.
- Handshake: a requester holds req and wr_data stable until it sees its gnt bit high. It then deasserts req, or keeps it high to request another write.
- Changing req or wr_data between edges has no effect; only values at the rising edge matter.
- Simultaneous requests: exactly one winner per cycle, and gnt is never more than one-hot. Losers keep waiting.
- Starvation bound: any requester holding req is granted within NUM_REQ cycles.
- Reset mid-operation: a pending request is dropped with no partial write. After release, arbitration restarts from ptr=0.
- Non-power-of-2 NUM_REQ: indices at or above NUM_REQ are never selected, and ptr never holds them.

Decomposition:
- Shared header/package:
  - clog2 function used for IDX_W.
  - Reset constants: all-zero data, all-zero grant, index 0.
- One sub-module: register_load_and_reset, instantiated for the q_out storage.
  - Parameterised to WIDTH.
  - Its reset_n input must be an asynchronous clear to 0.
  - load=1 captures data_in on the edge; load=0 holds.
- Arbiter logic, pointer, gnt, owner and valid live in the top module.

Test Plan:
1. Reset: hold reset_n=0 with any req -> q_out=4'h0, gnt=4'b0000, owner=0, valid=0. Then release reset_n with req=0 for 3 cycles -> all outputs stay unchanged.
2. Single requester: req=4'b0100 with wr_data[2]=4'b0011 -> after the next edge, q_out=4'b0011, gnt=4'b0100, owner=2, valid=1. With req still high, the following edge gives gnt=4'b0000 because of the mask, and the edge after that gives gnt=4'b0100 again.
3. Full contention: req=4'b1111 with requester i data=4'h1+i -> grants in order 0,1,2,3,0 and q_out sequence 1,2,3,4,1. gnt is never more than one-hot.
4. Wrap-around: after requester 2 wins (ptr=3), drive req=4'b1001 -> requester 3 wins first (q_out=wr_data[3]), then requester 0.
5. Reset mid-operation: under full contention, drive reset_n=0 between edges -> q_out, gnt, owner and valid clear before the next edge. Release with req=4'b0011 -> requester 0 wins first.
6. Idle hold: after requester 1 writes 4'hC, drive req=0 for 5 cycles -> q_out=4'hC, owner=1, valid=1 and gnt=0 throughout.
